// File: rtl/cache_controller.sv
// ============================================================================
//  Module      : cache_controller
//  Description : 2-way set-associative, 64-set, 2-word-line data cache for a
//                pipelined core. Loads hit in zero wait states and miss into a
//                line fill; stores are write-through with no write-allocate.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_controller (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   output logic [31:0] rdata,
   output logic        ready,
   output logic [31:0] sram_address,
   output logic [31:0] sram_wdata,
   output logic        sram_rd_en,
   output logic        sram_wr_en,
   input  logic [63:0] sram_rdata,
   input  logic        sram_ready
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   localparam logic [16:0] C_BASE_WORD = 17'd256;   // 1024 bytes expressed in words

   state_t state_q, state_d;

   // Storage: valid bits and LRU are reset, tags and data are not.
   logic [1:0]  valid_q [0:63];
   logic [63:0] lru_q;
   logic [9:0]  tag_q   [0:1][0:63];
   logic [63:0] data_q  [0:1][0:63];

   // Address decode relative to the 1024-byte base; the low two byte bits of
   // the base are zero, so only bits [18:2] take part in the subtraction.
   logic [18:2] w_off;
   logic        w_word;
   logic [5:0]  w_idx;
   logic [9:0]  w_tag;

   assign w_off  = address[18:2] - C_BASE_WORD;
   assign w_word = w_off[2];
   assign w_idx  = w_off[8:3];
   assign w_tag  = w_off[18:9];

   logic [1:0]  w_match;
   logic        w_any_match;
   logic        w_hit_way;
   logic        w_rd_hit;
   logic        w_victim;
   logic [63:0] w_hit_line;

   // Tag compare, hit way and victim choice for the current index.
   always_comb begin
      w_match[0]  = valid_q[w_idx][0] && (tag_q[0][w_idx] == w_tag);
      w_match[1]  = valid_q[w_idx][1] && (tag_q[1][w_idx] == w_tag);
      w_any_match = |w_match;
      w_hit_way   = w_match[1];
      w_rd_hit    = MEM_R_EN && w_any_match;
      w_hit_line  = data_q[w_hit_way][w_idx];
      if (!valid_q[w_idx][0])
         w_victim = 1'b0;
      else if (!valid_q[w_idx][1])
         w_victim = 1'b1;
      else
         w_victim = lru_q[w_idx];
   end

   assign sram_address = address;
   assign sram_wdata   = wdata;

   logic w_fill_we;     // install fetched line into the victim way
   logic w_whit_we;     // merge store data into the hitting way
   logic w_lru_we;
   logic w_lru_val;

   // Next-state and output decode.
   always_comb begin
      state_d    = state_q;
      ready      = 1'b1;
      rdata      = 32'd0;
      sram_rd_en = 1'b0;
      sram_wr_en = 1'b0;
      w_fill_we  = 1'b0;
      w_whit_we  = 1'b0;
      w_lru_we   = 1'b0;
      w_lru_val  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (MEM_W_EN) begin
               // Stores take priority over loads when both are requested.
               ready   = 1'b0;
               state_d = S_WRITE;
               if (w_any_match) begin
                  w_whit_we = 1'b1;
                  w_lru_we  = 1'b1;
                  w_lru_val = ~w_hit_way;
               end
            end else if (MEM_R_EN) begin
               if (w_rd_hit) begin
                  rdata     = w_word ? w_hit_line[63:32] : w_hit_line[31:0];
                  w_lru_we  = 1'b1;
                  w_lru_val = ~w_hit_way;
               end else begin
                  ready   = 1'b0;
                  state_d = S_FILL;
               end
            end
         end
         S_FILL: begin
            sram_rd_en = 1'b1;
            ready      = 1'b0;
            if (sram_ready) begin
               ready     = 1'b1;
               rdata     = w_word ? sram_rdata[63:32] : sram_rdata[31:0];
               w_fill_we = 1'b1;
               w_lru_we  = 1'b1;
               w_lru_val = ~w_victim;
               state_d   = S_IDLE;
            end
         end
         S_WRITE: begin
            sram_wr_en = 1'b1;
            ready      = 1'b0;
            if (sram_ready) begin
               ready   = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Valid bits and LRU; cleared by reset so an aborted fill leaves no trace.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++)
            valid_q[i] <= 2'b00;
         lru_q <= 64'd0;
      end else begin
         if (w_fill_we)
            valid_q[w_idx][w_victim] <= 1'b1;
         if (w_lru_we)
            lru_q[w_idx] <= w_lru_val;
      end
   end

   // Tag and data arrays; writes are suppressed while reset is asserted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_fill_we) begin
            tag_q[w_victim][w_idx]  <= w_tag;
            data_q[w_victim][w_idx] <= sram_rdata;
         end else if (w_whit_we) begin
            if (w_word)
               data_q[w_hit_way][w_idx][63:32] <= wdata;
            else
               data_q[w_hit_way][w_idx][31:0]  <= wdata;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cache_controller.sv
// ============================================================================
//  Module      : tb_cache_controller
//  Description : Directed self-checking bench for cache_controller with a
//                bench-driven SRAM responder of programmable latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_controller;

   logic        clk;
   logic        rst;
   logic [31:0] address;
   logic [31:0] wdata;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] rdata;
   logic        ready;
   logic [31:0] sram_address;
   logic [31:0] sram_wdata;
   logic        sram_rd_en;
   logic        sram_wr_en;
   logic [63:0] sram_rdata;
   logic        sram_ready;

   int checks = 0;
   int errors = 0;

   cache_controller dut (
      .clk          (clk),
      .rst          (rst),
      .address      (address),
      .wdata        (wdata),
      .MEM_R_EN     (MEM_R_EN),
      .MEM_W_EN     (MEM_W_EN),
      .rdata        (rdata),
      .ready        (ready),
      .sram_address (sram_address),
      .sram_wdata   (sram_wdata),
      .sram_rd_en   (sram_rd_en),
      .sram_wr_en   (sram_wr_en),
      .sram_rdata   (sram_rdata),
      .sram_ready   (sram_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hold reset for two edges; returns at a falling edge with reset released.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; sram_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic go_idle();
      MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; sram_ready = 1'b0;
      @(negedge clk);
   endtask

   // Load request; SRAM answers in cycle 'lat' counted from the request cycle.
   task automatic rd(input logic [31:0] addr, input int lat, input logic [63:0] line,
                     output int waits, output logic [31:0] data, output int rd_cycles);
      bit done;
      done = 1'b0; waits = -1; data = 32'hxxxxxxxx; rd_cycles = 0;
      address = addr; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; sram_rdata = line;
      for (int k = 0; k < 40 && !done; k++) begin
         sram_ready = (k == lat);
         #1;
         if (sram_rd_en) rd_cycles++;
         if (ready) begin
            waits = k; data = rdata; done = 1'b1;
         end
         @(negedge clk);
      end
      sram_ready = 1'b0;
      if (!done) MEM_R_EN = 1'b0;
   endtask

   // Store request (optionally with the load enable also raised).
   task automatic wr(input logic [31:0] addr, input logic [31:0] d, input int lat,
                     input bit both, output int waits, output int wr_cycles, output bit rd_seen);
      bit done;
      done = 1'b0; waits = -1; wr_cycles = 0; rd_seen = 1'b0;
      address = addr; wdata = d; MEM_W_EN = 1'b1; MEM_R_EN = both;
      for (int k = 0; k < 40 && !done; k++) begin
         sram_ready = (k == lat);
         #1;
         if (sram_wr_en) wr_cycles++;
         if (sram_rd_en) rd_seen = 1'b1;
         if (ready) begin
            waits = k; done = 1'b1;
         end
         @(negedge clk);
      end
      sram_ready = 1'b0;
      if (!done) begin MEM_W_EN = 1'b0; MEM_R_EN = 1'b0; end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
      checks++; if (sram_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", sram_rd_en); end
      checks++; if (sram_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", sram_wr_en); end
      address = 32'h1234_5678; wdata = 32'hCAFE_F00D;
      #1;
      checks++; if (sram_address !== 32'h1234_5678) begin errors++; $display("FAIL pass_addr got %h exp 12345678", sram_address); end
      checks++; if (sram_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL pass_wdata got %h exp cafef00d", sram_wdata); end
      // A stray SRAM completion while idle must be ignored.
      @(negedge clk);
      sram_ready = 1'b1;
      @(negedge clk);
      sram_ready = 1'b0;
      #1;
      checks++; if (ready !== 1'b1 || sram_rd_en !== 1'b0) begin errors++; $display("FAIL idle_sram_ready got ready=%b rd_en=%b exp 1/0", ready, sram_rd_en); end
      @(negedge clk);
   endtask

   task automatic test_cold_read();
      int w; int rc; logic [31:0] d;
      do_reset();
      rd(32'd1024, 5, 64'h22222222_11111111, w, d, rc);
      checks++; if (w !== 5) begin errors++; $display("FAIL cold_wait got %0d exp 5", w); end
      checks++; if (d !== 32'h11111111) begin errors++; $display("FAIL cold_data got %h exp 11111111", d); end
      checks++; if (rc !== 5) begin errors++; $display("FAIL cold_rd_en_cycles got %0d exp 5", rc); end
      rd(32'd1028, 5, 64'h0, w, d, rc);
      checks++; if (w !== 0) begin errors++; $display("FAIL hit1028_wait got %0d exp 0", w); end
      checks++; if (d !== 32'h22222222) begin errors++; $display("FAIL hit1028_data got %h exp 22222222", d); end
      checks++; if (rc !== 0) begin errors++; $display("FAIL hit1028_rd_en got %0d exp 0", rc); end
      go_idle();
   endtask

   task automatic test_eviction();
      int w; int rc; logic [31:0] d;
      do_reset();
      rd(32'd1024, 3, 64'hA0A0A0A0_00000A00, w, d, rc);
      rd(32'd1536, 3, 64'hB1B1B1B1_00000B00, w, d, rc);
      checks++; if (w !== 3) begin errors++; $display("FAIL ev_1536_fill_wait got %0d exp 3", w); end
      rd(32'd2048, 3, 64'hC2C2C2C2_00000C00, w, d, rc);
      checks++; if (w !== 3 || d !== 32'h00000C00) begin errors++; $display("FAIL ev_2048 got wait=%0d data=%h exp 3/00000c00", w, d); end
      rd(32'd1536, 3, 64'h0, w, d, rc);
      checks++; if (w !== 0 || d !== 32'h00000B00) begin errors++; $display("FAIL ev_1536_hit got wait=%0d data=%h exp 0/00000b00", w, d); end
      rd(32'd1024, 3, 64'hA0A0A0A0_00000A00, w, d, rc);
      checks++; if (w !== 3) begin errors++; $display("FAIL ev_1024_miss got wait=%0d exp 3", w); end
      go_idle();
   endtask

   task automatic test_lru();
      int w; int rc; logic [31:0] d;
      do_reset();
      rd(32'd1024, 2, 64'h11110001_10000001, w, d, rc);
      rd(32'd1536, 2, 64'h22220002_20000002, w, d, rc);
      rd(32'd1024, 2, 64'h0, w, d, rc);
      checks++; if (w !== 0 || d !== 32'h10000001) begin errors++; $display("FAIL lru_1024_hit got wait=%0d data=%h exp 0/10000001", w, d); end
      rd(32'd2048, 2, 64'h33330003_30000003, w, d, rc);
      checks++; if (w !== 2) begin errors++; $display("FAIL lru_2048_miss got wait=%0d exp 2", w); end
      rd(32'd1028, 2, 64'h0, w, d, rc);
      checks++; if (w !== 0 || d !== 32'h11110001) begin errors++; $display("FAIL lru_1028_hit got wait=%0d data=%h exp 0/11110001", w, d); end
      rd(32'd1536, 2, 64'h22220002_20000002, w, d, rc);
      checks++; if (w !== 2) begin errors++; $display("FAIL lru_1536_miss got wait=%0d exp 2", w); end
      go_idle();
   endtask

   task automatic test_write();
      int w; int rc; int wc; bit rs; logic [31:0] d;
      do_reset();
      rd(32'd1024, 3, 64'h22222222_11111111, w, d, rc);
      wr(32'd1028, 32'hDEADBEEF, 4, 1'b0, w, wc, rs);
      checks++; if (w !== 4) begin errors++; $display("FAIL wh_wait got %0d exp 4", w); end
      checks++; if (wc !== 4) begin errors++; $display("FAIL wh_wr_en_cycles got %0d exp 4", wc); end
      rd(32'd1028, 3, 64'h0, w, d, rc);
      checks++; if (w !== 0 || d !== 32'hDEADBEEF) begin errors++; $display("FAIL wh_readback got wait=%0d data=%h exp 0/deadbeef", w, d); end
      rd(32'd1024, 3, 64'h0, w, d, rc);
      checks++; if (w !== 0 || d !== 32'h11111111) begin errors++; $display("FAIL wh_other_word got wait=%0d data=%h exp 0/11111111", w, d); end
      wr(32'd4096, 32'h5555AAAA, 2, 1'b0, w, wc, rs);
      checks++; if (w !== 2) begin errors++; $display("FAIL wm_wait got %0d exp 2", w); end
      rd(32'd4096, 3, 64'h99999999_88888888, w, d, rc);
      checks++; if (w !== 3 || d !== 32'h88888888) begin errors++; $display("FAIL wm_no_alloc got wait=%0d data=%h exp 3/88888888", w, d); end
      go_idle();
   endtask

   task automatic test_both_enables();
      int w; int rc; int wc; bit rs; logic [31:0] d;
      do_reset();
      wr(32'd1024, 32'h0BADF00D, 3, 1'b1, w, wc, rs);
      checks++; if (w !== 3) begin errors++; $display("FAIL both_wait got %0d exp 3", w); end
      checks++; if (rs !== 1'b0) begin errors++; $display("FAIL both_rd_en got %b exp 0", rs); end
      checks++; if (wc !== 3) begin errors++; $display("FAIL both_wr_en_cycles got %0d exp 3", wc); end
      rd(32'd1024, 2, 64'h44444444_33333333, w, d, rc);
      checks++; if (w !== 2) begin errors++; $display("FAIL both_then_read got wait=%0d exp 2", w); end
      go_idle();
   endtask

   task automatic test_reset_in_fill();
      int w; int rc; logic [31:0] d;
      do_reset();
      rd(32'd1024, 2, 64'h66666666_55555555, w, d, rc);
      address = 32'd1536; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; sram_ready = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (sram_rd_en !== 1'b1) begin errors++; $display("FAIL rif_in_fill got %b exp 1", sram_rd_en); end
      @(negedge clk);
      rst = 1'b1; sram_ready = 1'b1; sram_rdata = 64'hEEEEEEEE_DDDDDDDD;
      @(negedge clk);
      rst = 1'b0; sram_ready = 1'b0; MEM_R_EN = 1'b0;
      #1;
      checks++; if (sram_rd_en !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL rif_after got rd_en=%b ready=%b exp 0/1", sram_rd_en, ready); end
      @(negedge clk);
      rd(32'd1024, 2, 64'h66666666_55555555, w, d, rc);
      checks++; if (w !== 2) begin errors++; $display("FAIL rif_1024_miss got wait=%0d exp 2", w); end
      rd(32'd1536, 2, 64'h78787878_12121212, w, d, rc);
      checks++; if (w !== 2 || d !== 32'h12121212) begin errors++; $display("FAIL rif_1536 got wait=%0d data=%h exp 2/12121212", w, d); end
      go_idle();
   endtask

   initial begin
      rst = 1'b1; address = 32'd0; wdata = 32'd0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
      sram_rdata = 64'd0; sram_ready = 1'b0;
      test_reset();
      test_cold_read();
      test_eviction();
      test_lru();
      test_write();
      test_both_enables();
      test_reset_in_fill();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
